// File: rtl/rom16x1_reader_pkg.sv
// Shared definitions for the ROM16X1 readback sequencer: scan state encoding,
// address geometry and the wrapping address increment.
package rom16x1_reader_pkg;

    localparam int ADR_W = 4;
    localparam int DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // 15 rolls over to 0 so a scan with LAST < FIRST walks through the top of the ROM
    function automatic logic [ADR_W-1:0] adr_wrap_inc(input logic [ADR_W-1:0] adr);
        return adr + ADR_W'(1);
    endfunction

endpackage

// File: rtl/rom16x1_adr_seq.sv
// Address sequencer for the ROM scan: holds the ROM address, the settle
// down-counter and the latched last address; flags when O may be sampled.
module rom16x1_adr_seq
    import rom16x1_reader_pkg::*;
#(
    parameter logic [ADR_W-1:0] SETTLE_CYCLES = 4'd1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_active,
    input  logic [ADR_W-1:0] i_first,
    input  logic [ADR_W-1:0] i_last,
    output logic [ADR_W-1:0] o_adr,
    output logic             o_sample_en,
    output logic             o_at_last
);

    logic [ADR_W-1:0] r_adr;
    logic [ADR_W-1:0] r_cnt;
    logic [ADR_W-1:0] r_last;

    // Address/counter update: load on scan start, count down, then step to the next address
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_adr  <= {ADR_W{1'b0}};
            r_cnt  <= {ADR_W{1'b0}};
            r_last <= {ADR_W{1'b0}};
        end else if (i_load) begin
            r_adr  <= i_first;
            r_cnt  <= SETTLE_CYCLES;
            r_last <= i_last;
        end else if (i_active) begin
            if (r_cnt != {ADR_W{1'b0}}) begin
                r_cnt <= r_cnt - ADR_W'(1);
            end else if (r_adr != r_last) begin
                r_adr <= adr_wrap_inc(r_adr);
                r_cnt <= SETTLE_CYCLES;
            end
        end
    end

    assign o_adr       = r_adr;
    assign o_sample_en = i_active && (r_cnt == {ADR_W{1'b0}});
    assign o_at_last   = (r_adr == r_last);

endmodule

// File: rtl/rom16x1_reader.sv
// ROM16X1 readback sequencer: scans an address range, samples O after a settle
// time and returns the assembled DATA/MASK words on a VALID/READY handshake.
module rom16x1_reader
    import rom16x1_reader_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [ADR_W-1:0] i_first_adr,
    input  logic [ADR_W-1:0] i_last_adr,
    output logic             o_a0,
    output logic             o_a1,
    output logic             o_a2,
    output logic             o_a3,
    input  logic             i_o_in,
    output logic [DEPTH-1:0] o_data,
    output logic [DEPTH-1:0] o_mask,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy
);

    localparam logic [ADR_W-1:0] L_SETTLE = ADR_W'(SETTLE_CYCLES);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_active;
    logic             w_sample_en;
    logic             w_at_last;
    logic [ADR_W-1:0] w_adr;
    logic [DEPTH-1:0] r_data;
    logic [DEPTH-1:0] r_mask;
    logic             r_valid;
    logic             r_busy;

    assign w_active = (r_state == ST_SETTLE);

    rom16x1_adr_seq #(
        .SETTLE_CYCLES (L_SETTLE)
    ) u_adr_seq (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_active    (w_active),
        .i_first     (i_first_adr),
        .i_last      (i_last_adr),
        .o_adr       (w_adr),
        .o_sample_en (w_sample_en),
        .o_at_last   (w_at_last)
    );

    // Scan state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; START is only honoured when sampled in IDLE
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = ST_SETTLE;
                    w_load = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (w_sample_en && w_at_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_DONE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // DATA/MASK capture: cleared at scan start, one bit written per sampled address
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data <= {DEPTH{1'b0}};
            r_mask <= {DEPTH{1'b0}};
        end else if (w_load) begin
            r_data <= {DEPTH{1'b0}};
            r_mask <= {DEPTH{1'b0}};
        end else if (w_sample_en) begin
            r_data[w_adr] <= i_o_in;
            r_mask[w_adr] <= 1'b1;
        end
    end

    // Status flags registered from the next state so they line up with r_state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= (w_next == ST_DONE);
            r_busy  <= (w_next != ST_IDLE);
        end
    end

    assign o_a0    = w_adr[0];
    assign o_a1    = w_adr[1];
    assign o_a2    = w_adr[2];
    assign o_a3    = w_adr[3];
    assign o_data  = r_data;
    assign o_mask  = r_mask;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_rom16x1_reader.sv
// Bench for rom16x1_reader: two instances (settle 1 and settle 0) scan a modelled
// ROM16X1 side by side; expectations come from the scan timing rules and INIT.
module tb_rom16x1_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  first;
    logic [3:0]  last;
    logic        ready;
    logic [15:0] rom_init;

    logic        s1_a0, s1_a1, s1_a2, s1_a3, s1_o, s1_valid, s1_busy;
    logic [15:0] s1_data, s1_mask;
    logic [3:0]  s1_adr;
    logic        s0_a0, s0_a1, s0_a2, s0_a3, s0_o, s0_valid, s0_busy;
    logic [15:0] s0_data, s0_mask;
    logic [3:0]  s0_adr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign s1_adr = {s1_a3, s1_a2, s1_a1, s1_a0};
    assign s0_adr = {s0_a3, s0_a2, s0_a1, s0_a0};
    assign s1_o   = rom_init[s1_adr];
    assign s0_o   = rom_init[s0_adr];

    rom16x1_reader #(.SETTLE_CYCLES(1)) dut_s1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_first_adr(first), .i_last_adr(last),
        .o_a0(s1_a0), .o_a1(s1_a1), .o_a2(s1_a2), .o_a3(s1_a3),
        .i_o_in(s1_o), .o_data(s1_data), .o_mask(s1_mask),
        .o_valid(s1_valid), .i_ready(ready), .o_busy(s1_busy)
    );

    rom16x1_reader #(.SETTLE_CYCLES(0)) dut_s0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_first_adr(first), .i_last_adr(last),
        .o_a0(s0_a0), .o_a1(s0_a1), .o_a2(s0_a2), .o_a3(s0_a3),
        .i_o_in(s0_o), .o_data(s0_data), .o_mask(s0_mask),
        .o_valid(s0_valid), .i_ready(ready), .o_busy(s0_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " s1 adr"},   {28'd0, s1_adr}, 32'd0);
        chk({nm, " s1 data"},  {16'd0, s1_data}, 32'd0);
        chk({nm, " s1 mask"},  {16'd0, s1_mask}, 32'd0);
        chk({nm, " s1 valid"}, {31'd0, s1_valid}, 32'd0);
        chk({nm, " s1 busy"},  {31'd0, s1_busy}, 32'd0);
        chk({nm, " s0 adr"},   {28'd0, s0_adr}, 32'd0);
        chk({nm, " s0 data"},  {16'd0, s0_data}, 32'd0);
        chk({nm, " s0 mask"},  {16'd0, s0_mask}, 32'd0);
        chk({nm, " s0 valid"}, {31'd0, s0_valid}, 32'd0);
        chk({nm, " s0 busy"},  {31'd0, s0_busy}, 32'd0);
    endtask

    // Reference: address k of the scan is shown for settle+1 cycles starting at cycle 1
    task automatic chk_inst(input string nm, input int c, input int settle, input int t_valid,
                            input bit dn, input logic [3:0] f, input logic [3:0] l,
                            input logic [3:0] adr, input logic [15:0] d, input logic [15:0] m,
                            input logic v, input logic b,
                            input logic [15:0] exp_d, input logic [15:0] exp_m);
        logic [3:0] exp_adr;
        if (c >= t_valid) exp_adr = l;
        else              exp_adr = 4'((int'(f) + (c - 1) / (settle + 1)) % 16);
        chk($sformatf("%s c=%0d adr", nm, c),   {28'd0, adr}, {28'd0, exp_adr});
        chk($sformatf("%s c=%0d valid", nm, c), {31'd0, v},   {31'd0, (c >= t_valid) && !dn});
        chk($sformatf("%s c=%0d busy", nm, c),  {31'd0, b},   {31'd0, !dn});
        if (c == 1) begin
            chk($sformatf("%s c=1 data clr", nm), {16'd0, d}, 32'd0);
            chk($sformatf("%s c=1 mask clr", nm), {16'd0, m}, 32'd0);
        end
        if (c >= t_valid) begin
            chk($sformatf("%s c=%0d data", nm, c), {16'd0, d}, {16'd0, exp_d});
            chk($sformatf("%s c=%0d mask", nm, c), {16'd0, m}, {16'd0, exp_m});
        end
    endtask

    // hold >= 0: READY rises hold cycles after the settle-1 VALID; hold < 0: random READY
    task automatic run_scan(input logic [3:0] f, input logic [3:0] l, input int hold, input bit noise);
        int n, t0, t1;
        bit done0, done1, rdy;
        logic [15:0] exp_m, exp_d;
        n = ((int'(l) - int'(f)) & 15) + 1;
        t0 = 1 + n;
        t1 = 1 + 2 * n;
        exp_m = 16'd0;
        for (int k = 0; k < n; k++) exp_m[(int'(f) + k) % 16] = 1'b1;
        exp_d = rom_init & exp_m;
        first = f; last = l; ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        done0 = 1'b0; done1 = 1'b0;
        for (int c = 1; c < 400; c++) begin
            chk_inst("s1", c, 1, t1, done1, f, l, s1_adr, s1_data, s1_mask, s1_valid, s1_busy, exp_d, exp_m);
            chk_inst("s0", c, 0, t0, done0, f, l, s0_adr, s0_data, s0_mask, s0_valid, s0_busy, exp_d, exp_m);
            if (done0 && done1) break;
            if (hold >= 0) rdy = (c >= t1 + hold);
            else           rdy = ($urandom_range(1, 0) == 1) || (c >= t1 + 6);
            ready = rdy;
            start = noise && !done0 && !done1 && ($urandom_range(2, 0) == 0);
            if (noise) begin
                first = 4'($urandom);
                last  = 4'($urandom);
            end
            if (c >= t0 && rdy) done0 = 1'b1;
            if (c >= t1 && rdy) done1 = 1'b1;
            step();
        end
        chk("scan completes", {30'd0, done0, done1}, 32'd3);
        start = 1'b0;
        ready = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; first = 4'd0; last = 4'd0; ready = 1'b0;
        rom_init = 16'hA5C3;
        step();
        step();
        rst_n = 1'b1;
        chk_zero("reset");

        run_scan(4'd0,  4'd15, 0, 1'b0);
        run_scan(4'd4,  4'd7,  0, 1'b0);
        run_scan(4'd14, 4'd1,  0, 1'b0);
        run_scan(4'd5,  4'd5,  0, 1'b0);
        run_scan(4'd2,  4'd9,  5, 1'b1);

        // Abort a full scan with reset at cycle 10
        first = 4'd0; last = 4'd15; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_zero("mid-scan reset");
        step();
        chk_zero("idle after reset");
        run_scan(4'd0, 4'd15, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rom_init = 16'($urandom);
            run_scan(4'($urandom), 4'($urandom), -1, ($urandom_range(1, 0) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
